inner_ebi_master: RTL and testbench

- Chip-side peer of the outer EBI bridge, on the far end of the 16-bit GPIO link.
- Accepts cache-line read/write requests from the core-side miss unit and serializes each into one EBI frame.
- Deserializes the response frame (read data or ack) and returns it on a response channel.
- Owns the bus after reset. Lends the bus to the peer on request so the peer can send snoops, then reclaims it.

---
 rtl/ebi_pkg.sv | 22 ++
 rtl/ebi_slot_shifter.sv | 26 ++
 rtl/inner_ebi_master.sv | 115 +++++++++++
 tb/tb_inner_ebi_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ebi_pkg.sv
// ebi_pkg: shared EBI link constants, opcodes and master FSM states
package ebi_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int PADDR_WIDTH = 32;
  localparam int CACHELINE_LENGTH = 512;
  localparam int EBI_WIDTH = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam logic [15:0] START_WORD = 16'hA5A5;
  localparam logic [3:0] OP_DR = 4'h0;
  localparam logic [3:0] OP_DW1 = 4'h1;
  localparam logic [3:0] OP_DW2 = 4'h2;
  localparam logic [3:0] OP_RD_RESP = 4'h7;
  localparam logic [3:0] OP_ACK = 4'hF;
  localparam int HDR_SLOTS = 5;
  localparam int LINE_SLOTS = 32;
  localparam int DW2_SLOTS = HDR_SLOTS + LINE_SLOTS;
  localparam int RD_RESP_SLOTS = 3 + LINE_SLOTS;
  localparam int ACK_SLOTS = 2;
  typedef enum logic [3:0] {
    S_IDLE, S_SEND, S_WAIT, S_RECV, S_OUT, S_LEND, S_LENT, S_ASK, S_RECLAIM
  } state_t;
endpackage

// File: rtl/ebi_slot_shifter.sv
// ebi_slot_shifter: slot counter, outgoing slot mux and incoming line shifter
module ebi_slot_shifter
  import ebi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic rx_en,
  input  logic [79:0] hdr,
  input  logic [CACHELINE_LENGTH-1:0] tx_line,
  input  logic [EBI_WIDTH-1:0] ebi_i,
  output logic [5:0] cnt,
  output logic [EBI_WIDTH-1:0] tx_slot,
  output logic [CACHELINE_LENGTH-1:0] rx_line
);
  logic [4:0] idx;
  assign idx = cnt[4:0] - 5'd5;
  assign tx_slot = (cnt < 6'(HDR_SLOTS)) ? hdr[{cnt[2:0], 4'b0} +: 16] : tx_line[{idx, 4'b0} +: 16];
  always_ff @(posedge clk) begin
    cnt <= (rst || clr) ? 6'd0 : cnt + 6'd1;
    if (rst)
      rx_line <= '0;
    else if (rx_en)
      rx_line <= {ebi_i, rx_line[CACHELINE_LENGTH-1:16]};
  end
endmodule

// File: rtl/inner_ebi_master.sv
// inner_ebi_master: chip-side EBI master serializing line requests and lending the bus to the peer
module inner_ebi_master
  import ebi_pkg::*;
#(parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES)
(
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_is_write,
  input  logic req_has_data,
  input  logic [PADDR_WIDTH-1:0] req_addr,
  input  logic [3:0] req_attr,
  input  logic [CACHELINE_LENGTH-1:0] req_data,
  output logic resp_valid,
  input  logic resp_ready,
  output logic resp_is_ack,
  output logic resp_err,
  output logic [CACHELINE_LENGTH-1:0] resp_data,
  output logic [1:0] resp_mesi,
  input  logic [EBI_WIDTH-1:0] ebi_i,
  output logic [EBI_WIDTH-1:0] ebi_o,
  output logic [EBI_WIDTH-1:0] ebi_oen,
  input  logic bus_switch_i,
  output logic bus_switch_o,
  output logic bus_switch_oen
);
  state_t state, nstate;
  logic owner, ask_pend, tmo, req_fire, done, rx_en, waiting;
  logic [5:0] cnt, last_slot;
  logic [3:0] op;
  logic [15:0] attr_slot, tx_slot;
  logic [79:0] hdr;
  logic [CACHELINE_LENGTH-1:0] line_q, rx_line;
  assign req_fire = req_valid && req_ready;
  assign op = !req_is_write ? OP_DR : req_has_data ? OP_DW2 : OP_DW1;
  assign attr_slot = req_is_write ? {14'b0, req_attr[1:0]} : {12'b0, req_attr};
  assign last_slot = (hdr[19:16] == OP_DW2) ? 6'(DW2_SLOTS - 1) : 6'(HDR_SLOTS - 1);
  assign waiting = (state == S_WAIT) || (state == S_RECV);
  assign done = (state == S_RECV) && ((cnt == 6'd0 && ebi_i == {12'b0, OP_ACK}) || cnt == 6'(RD_RESP_SLOTS - 2));
  assign rx_en = (state == S_RECV) && cnt >= 6'd1 && cnt <= 6'(LINE_SLOTS);
  ebi_slot_shifter u_shift (
    .clk(clk), .rst(rst), .clr(nstate != state), .rx_en(rx_en), .hdr(hdr), .tx_line(line_q),
    .ebi_i(ebi_i), .cnt(cnt), .tx_slot(tx_slot), .rx_line(rx_line)
  );
`ifdef INNER_EBI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk)
    tcnt <= (rst || !waiting) ? '0 : tcnt + 1'b1;
  assign tmo = waiting && tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= 1'b1;
      ask_pend <= 1'b0;
    end else begin
      state <= nstate;
      owner <= !(nstate inside {S_LENT, S_ASK, S_RECLAIM});
      ask_pend <= (state == S_LEND) ? 1'b0 : (owner && bus_switch_i) ? 1'b1 : ask_pend;
    end
  end
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:    nstate = req_fire ? S_SEND : ask_pend ? S_LEND : S_IDLE;
      S_SEND:    nstate = (cnt == last_slot) ? S_WAIT : S_SEND;
      S_WAIT:    nstate = tmo ? S_OUT : (ebi_i == START_WORD) ? S_RECV : S_WAIT;
      S_RECV:    nstate = (tmo || done) ? S_OUT : (cnt == 6'd0 && ebi_i != {12'b0, OP_RD_RESP}) ? S_WAIT : S_RECV;
      S_OUT:     nstate = resp_ready ? S_IDLE : S_OUT;
      S_LEND:    nstate = S_LENT;
      S_LENT:    nstate = bus_switch_i ? S_IDLE : req_valid ? S_ASK : S_LENT;
      S_ASK:     nstate = bus_switch_i ? S_IDLE : S_RECLAIM;
      S_RECLAIM: nstate = bus_switch_i ? S_IDLE : S_RECLAIM;
      default:   nstate = S_IDLE;
    endcase
  end
  always_comb begin
    req_ready = !rst && state == S_IDLE && owner && !ask_pend;
    resp_valid = state == S_OUT;
    ebi_oen = (state == S_SEND) ? '0 : '1;
    ebi_o = (state == S_SEND) ? tx_slot : '0;
    bus_switch_o = (state == S_LEND) || (state == S_ASK);
    bus_switch_oen = (state == S_LENT) || (state == S_RECLAIM);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr <= '0;
      line_q <= '0;
      resp_is_ack <= 1'b0;
      resp_err <= 1'b0;
      resp_data <= '0;
      resp_mesi <= 2'b0;
    end else begin
      if (req_fire) begin
        hdr <= {attr_slot, req_addr[PADDR_WIDTH-1:16], req_addr[15:0], 12'b0, op, START_WORD};
        line_q <= req_data;
      end
      if (tmo) begin
        resp_is_ack <= 1'b0;
        resp_err <= 1'b1;
        resp_data <= '0;
        resp_mesi <= 2'b0;
      end else if (done) begin
        resp_is_ack <= cnt == 6'd0;
        resp_err <= 1'b0;
        resp_data <= (cnt == 6'd0) ? '0 : rx_line;
        resp_mesi <= (cnt == 6'd0) ? 2'b0 : ebi_i[1:0];
      end
    end
  end
endmodule

// File: tb/tb_inner_ebi_master.sv
// tb_inner_ebi_master: directed self-checking bench for inner_ebi_master
module tb_inner_ebi_master;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_is_write = 0, req_has_data = 0;
  logic [31:0] req_addr = 0;
  logic [3:0] req_attr = 0;
  logic [511:0] req_data = 0;
  logic resp_valid, resp_ready = 0, resp_is_ack, resp_err;
  logic [511:0] resp_data;
  logic [1:0] resp_mesi;
  logic [15:0] ebi_i = 0, ebi_o, ebi_oen;
  logic bus_switch_i = 0, bus_switch_o, bus_switch_oen;
  int checks = 0, errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rx_q[$];
  always #5 clk = ~clk;
  inner_ebi_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_has_data(req_has_data), .req_addr(req_addr), .req_attr(req_attr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_is_ack(resp_is_ack), .resp_err(resp_err),
    .resp_data(resp_data), .resp_mesi(resp_mesi), .ebi_i(ebi_i), .ebi_o(ebi_o), .ebi_oen(ebi_oen),
    .bus_switch_i(bus_switch_i), .bus_switch_o(bus_switch_o), .bus_switch_oen(bus_switch_oen)
  );

  function automatic logic [511:0] mk_line(input logic [15:0] base);
    logic [511:0] l;
    for (int k = 0; k < 32; k++) l[16*k +: 16] = base + 16'(k);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic w, input logic d, input logic [31:0] a, input logic [3:0] at, input logic [511:0] data);
    req_is_write = w; req_has_data = d; req_addr = a; req_attr = at; req_data = data; req_valid = 1;
    chk("req_ready_idle", req_ready, 1);
    step();
    req_valid = 0;
  endtask

  task automatic check_slots();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ebi_oen !== 16'h0 || ebi_o !== exp_q[i]) begin
        errors++;
        $display("FAIL slot%0d: oen %h o %h expected oen 0000 o %h", i, ebi_oen, ebi_o, exp_q[i]);
      end
      step();
    end
    chk("oen_turnaround", ebi_oen, 16'hFFFF);
  endtask

  task automatic peer_send();
    foreach (rx_q[i]) begin
      ebi_i = rx_q[i];
      if (i == rx_q.size() - 1) chk("resp_valid_early", resp_valid, 0);
      step();
    end
    ebi_i = 0;
    chk("resp_valid_latency", resp_valid, 1);
  endtask

  task automatic accept();
    resp_ready = 1;
    step();
    resp_ready = 0;
  endtask

  task automatic peer_ack();
    rx_q = '{16'hA5A5, 16'h000F};
    peer_send();
    chk("ack_is_ack", resp_is_ack, 1);
    chk("ack_err", resp_err, 0);
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_fields", {resp_is_ack, resp_err, resp_mesi}, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_ebi_o", ebi_o, 0);
    chk("rst_ebi_oen", ebi_oen, 16'hFFFF);
    chk("rst_switch", {bus_switch_o, bus_switch_oen}, 0);
    rst = 0;
    step();
    chk("post_rst_ready", req_ready, 1);
  endtask

  task automatic test_read();
    send_req(0, 0, 32'h8000_1240, 4'h3, '0);
    exp_q = '{16'hA5A5, 16'h0000, 16'h1240, 16'h8000, 16'h0003};
    check_slots();
    rx_q = '{16'hA5A5, 16'h0007};
    for (int k = 0; k < 32; k++) rx_q.push_back(16'h0100 + 16'(k));
    rx_q.push_back(16'h0002);
    peer_send();
    chk("rd_data", resp_data, mk_line(16'h0100));
    chk("rd_mesi", resp_mesi, 2);
    chk("rd_is_ack", resp_is_ack, 0);
    accept();
    chk("rd_back_idle", req_ready, 1);
  endtask

  task automatic test_dw2();
    send_req(1, 1, 32'h1234_5678, 4'hE, mk_line(16'hDEAD));
    exp_q = '{16'hA5A5, 16'h0002, 16'h5678, 16'h1234, 16'h0002};
    for (int k = 0; k < 32; k++) exp_q.push_back(16'hDEAD + 16'(k));
    check_slots();
    peer_ack();
    accept();
  endtask

  task automatic test_dw1();
    send_req(1, 0, 32'hCAFE_0040, 4'h5, mk_line(16'h7777));
    exp_q = '{16'hA5A5, 16'h0001, 16'h0040, 16'hCAFE, 16'h0001};
    check_slots();
    peer_ack();
    accept();
  endtask

  task automatic test_unknown_opcode();
    send_req(1, 0, 32'h0000_0080, 4'h1, '0);
    exp_q = '{16'hA5A5, 16'h0001, 16'h0080, 16'h0000, 16'h0001};
    check_slots();
    ebi_i = 16'hA5A5; step();
    ebi_i = 16'h0003; step();
    ebi_i = 16'h0000; step();
    chk("unk_dropped", resp_valid, 0);
    peer_ack();
    accept();
  endtask

  task automatic test_backpressure();
    send_req(0, 0, 32'h0000_1000, 4'h1, '0);
    exp_q = '{16'hA5A5, 16'h0000, 16'h1000, 16'h0000, 16'h0001};
    check_slots();
    rx_q = '{16'hA5A5, 16'h0007};
    for (int k = 0; k < 32; k++) rx_q.push_back(16'h3000 + 16'(k));
    rx_q.push_back(16'h0001);
    peer_send();
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", resp_valid, 1);
      chk("bp_data", resp_data, mk_line(16'h3000));
      chk("bp_ready", req_ready, 0);
      step();
    end
    chk("bp_mesi", resp_mesi, 1);
    accept();
    chk("bp_released", resp_valid, 0);
  endtask

  task automatic test_lend();
    bus_switch_i = 1; step(); bus_switch_i = 0;
    chk("lend_ready_blocked", req_ready, 0);
    step();
    chk("lend_pulse", {bus_switch_o, bus_switch_oen}, 2'b10);
    step();
    chk("lent_switch", {bus_switch_o, bus_switch_oen}, 2'b01);
    chk("lent_oen", ebi_oen, 16'hFFFF);
    chk("lent_ready", req_ready, 0);
    req_is_write = 1; req_has_data = 0; req_addr = 32'h0BAD_F00D; req_attr = 4'h3; req_valid = 1;
    step();
    chk("ask_pulse", {bus_switch_o, bus_switch_oen}, 2'b10);
    step();
    chk("ask_listen", {bus_switch_o, bus_switch_oen}, 2'b01);
    step();
    chk("reclaim_ready", req_ready, 0);
    bus_switch_i = 1; step(); bus_switch_i = 0;
    chk("reclaimed_ready", req_ready, 1);
    chk("reclaimed_oen", bus_switch_oen, 0);
    step();
    req_valid = 0;
    exp_q = '{16'hA5A5, 16'h0001, 16'hF00D, 16'h0BAD, 16'h0003};
    check_slots();
    peer_ack();
    accept();
  endtask

  task automatic test_req_vs_ask();
    req_is_write = 1; req_has_data = 0; req_addr = 32'h0000_0200; req_attr = 4'h2; req_valid = 1;
    bus_switch_i = 1;
    chk("race_ready", req_ready, 1);
    step();
    req_valid = 0; bus_switch_i = 0;
    exp_q = '{16'hA5A5, 16'h0001, 16'h0200, 16'h0000, 16'h0002};
    check_slots();
    peer_ack();
    accept();
    chk("race_ask_pending", req_ready, 0);
    step();
    chk("race_lend_pulse", bus_switch_o, 1);
    step();
    chk("race_lent", bus_switch_oen, 1);
    bus_switch_i = 1; step(); bus_switch_i = 0;
    chk("peer_return_owner", req_ready, 1);
  endtask

  task automatic test_midframe_reset();
    send_req(1, 1, 32'h4444_0000, 4'h0, mk_line(16'h1111));
    repeat (10) step();
    chk("mid_sending", ebi_oen, 16'h0);
    rst = 1; step();
    chk("mid_rst_oen", ebi_oen, 16'hFFFF);
    chk("mid_rst_o", ebi_o, 0);
    rst = 0; step();
    chk("mid_rst_idle", req_ready, 1);
  endtask

`ifdef INNER_EBI_TIMEOUT_EN
  task automatic test_timeout();
    send_req(0, 0, 32'h0000_0400, 4'h0, '0);
    exp_q = '{16'hA5A5, 16'h0000, 16'h0400, 16'h0000, 16'h0000};
    check_slots();
    for (int c = 0; c < 16; c++) begin
      chk("tmo_not_yet", resp_valid, 0);
      step();
    end
    chk("tmo_valid", resp_valid, 1);
    chk("tmo_err", resp_err, 1);
    chk("tmo_data", resp_data, 0);
    accept();
    ebi_i = 16'hA5A5; step(); ebi_i = 0; step();
    chk("tmo_late_start_ignored", resp_valid, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_dw2();
    test_dw1();
    test_unknown_opcode();
    test_backpressure();
    test_lend();
    test_req_vs_ask();
    test_midframe_reset();
`ifdef INNER_EBI_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
